nes_pad_responder: RTL and testbench

- Controller-side end of the serial pad link carried on HDR2 (latch, pulse, data).
- The console top drives latch and pulse and samples data. This block answers that traffic the way a shift-register game pad does.
- It serves as the pad model in gameboycolorsim, replacing the tied-off latch/pulse/data wires.
- It can also run on a second board to feed DIP-switch buttons to the console.
- The button vector is loaded while latch is high and is then shifted out one bit per pulse rising edge.

---
 rtl/nes_pad_responder_pkg.sv | 29 ++
 rtl/pad_sync_edge.sv | 35 +++
 rtl/nes_pad_responder.sv | 101 ++++++++++
 tb/tb_nes_pad_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pad_responder_pkg.sv
// Shared pad definitions: button bit order, FSM encoding and pin-level helper.
// Both the pad responder and the console-side reader import this package.
package nes_pad_responder_pkg;

  // Button bit positions within a frame; bit 0 leaves the pad first.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int DEFAULT_NUM_BUTTONS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } pad_state_e;

  // Converts a pressed/released button bit into the level driven on the data pin.
  function automatic logic pin_level(input logic pressed, input bit active_low);
    return active_low ? ~pressed : pressed;
  endfunction

endpackage

// File: rtl/pad_sync_edge.sv
// Multi-flop synchronizer for one asynchronous console pin, followed by
// registered one-cycle rise/fall strobes.
module pad_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // NOTE: non-blocking assignments let every flop sample the pre-edge values,
  // so the chain shifts by exactly one stage per clock regardless of order.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= synced;
      rise   <= synced & ~prev_q;
      fall   <= ~synced & prev_q;
    end
  end

endmodule

// File: rtl/nes_pad_responder.sv
// Pad end of the latch/pulse/data serial link: loads the button vector while
// latch is high and shifts it out one bit per pulse rising edge.
module nes_pad_responder
  import nes_pad_responder_pkg::*;
#(
  parameter int NUM_BUTTONS = DEFAULT_NUM_BUTTONS,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit FILL_LEVEL  = 1'b0,
  localparam int CW         = $clog2(NUM_BUTTONS + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   latch,
  input  logic                   pulse,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic                   data,
  output logic                   frame_done,
  output logic [CW-1:0]          shift_count
);

  pad_state_e             state;
  logic [NUM_BUTTONS-1:0] shadow;

  logic latch_rise;
  logic latch_fall;
  logic pulse_rise;
  logic pulse_fall_unused;

  logic [NUM_BUTTONS-1:0] shift_src;
  logic [NUM_BUTTONS-1:0] shifted;
  logic [CW-1:0]          count_inc;
  logic                   last_shift;
  logic                   do_shift;

  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (latch),
    .rise     (latch_rise),
    .fall     (latch_fall)
  );

  // Falling pulse edges carry no meaning for a shift-register pad.
  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (pulse),
    .rise     (pulse_rise),
    .fall     (pulse_fall_unused)
  );

  // NOTE: every signal gets a value on every path through always_comb;
  // a missing assignment would infer a latch.
  always_comb begin
    // A pulse landing on the latch fall shifts the value frozen this very cycle.
    shift_src  = (state == ST_LOAD) ? buttons : shadow;
    shifted    = shift_src >> 1;
    count_inc  = shift_count + CW'(1);
    last_shift = (count_inc == CW'(NUM_BUTTONS));
    do_shift   = pulse_rise && ((state == ST_SHIFT) ||
                                (state == ST_LOAD && latch_fall));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      shadow      <= '0;
      data        <= ACTIVE_LOW;
      frame_done  <= 1'b0;
      shift_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (latch_rise) begin
        // Latch wins over any coincident pulse; also abandons a partial frame.
        state       <= ST_LOAD;
        shadow      <= buttons;
        data        <= pin_level(buttons[0], ACTIVE_LOW);
        shift_count <= '0;
      end else if (do_shift) begin
        shadow      <= shifted;
        shift_count <= count_inc;
        if (last_shift) begin
          state      <= ST_DONE;
          frame_done <= 1'b1;
          data       <= FILL_LEVEL;
        end else begin
          state <= ST_SHIFT;
          data  <= pin_level(shifted[0], ACTIVE_LOW);
        end
      end else if (state == ST_LOAD) begin
        shadow <= buttons;
        data   <= pin_level(buttons[0], ACTIVE_LOW);
        if (latch_fall) begin
          state <= ST_SHIFT;
        end
      end
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// Scoreboard bench for nes_pad_responder: stimulus queues timed expectations,
// a negedge monitor pops and compares them against the pad outputs.
module tb_nes_pad_responder;

  localparam int NUM_BUTTONS = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CW          = $clog2(NUM_BUTTONS + 1);
  // Cycles from driving a pin (just after an edge) to the visible data update.
  localparam int LAT         = SYNC_STAGES + 2;

  typedef struct {
    string name;
    int    due;
    logic  d;
    logic  fd;
    int    cnt;
    int    fdt;
  } exp_t;

  logic                   clock;
  logic                   reset;
  logic                   latch;
  logic                   pulse;
  logic [NUM_BUTTONS-1:0] buttons;
  logic                   data;
  logic                   frame_done;
  logic [CW-1:0]          shift_count;

  exp_t q[$];
  int   cycle;
  int   fd_total;
  int   tests_run;
  int   tests_failed;

  // Bench-side expectation of the outputs between actions.
  logic m_d;
  int   m_cnt;
  int   m_fdt;

  nes_pad_responder #(
    .NUM_BUTTONS (NUM_BUTTONS),
    .SYNC_STAGES (SYNC_STAGES),
    .ACTIVE_LOW  (1'b1),
    .FILL_LEVEL  (1'b0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .latch       (latch),
    .pulse       (pulse),
    .buttons     (buttons),
    .data        (data),
    .frame_done  (frame_done),
    .shift_count (shift_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  // Monitor: compare every expectation that falls due in this cycle.
  always @(negedge clock) begin
    int i;
    exp_t e;
    if (frame_done === 1'b1) fd_total++;
    i = 0;
    while (i < q.size()) begin
      e = q[i];
      if (e.due <= cycle) begin
        q.delete(i);
        tests_run++;
        if (e.due < cycle) begin
          tests_failed++;
          $display("FAIL %s: check missed, due cycle %0d seen at %0d", e.name, e.due, cycle);
        end else if (data !== e.d || frame_done !== e.fd || int'(shift_count) != e.cnt ||
                     fd_total != e.fdt) begin
          tests_failed++;
          $display("FAIL %s @%0d: data=%0b exp %0b frame_done=%0b exp %0b shift_count=%0d exp %0d frames=%0d exp %0d",
                   e.name, cycle, data, e.d, frame_done, e.fd, shift_count, e.cnt, fd_total, e.fdt);
        end
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push(input string name, input int off, input logic d, input logic fd,
                      input int cnt, input int fdt);
    exp_t e;
    e.name = name;
    e.due  = cycle + off;
    e.d    = d;
    e.fd   = fd;
    e.cnt  = cnt;
    e.fdt  = fdt;
    q.push_back(e);
  endtask

  // Drive latch/pulse, then expect the old outputs one cycle before the update,
  // the new outputs exactly at the update, and frame_done cleared a cycle later.
  task automatic act(input string name, input logic l, input logic p,
                     input logic d, input int cnt, input bit fd);
    push({name, "_pre"}, LAT - 1, m_d, 1'b0, m_cnt, m_fdt);
    m_d   = d;
    m_cnt = cnt;
    if (fd) m_fdt++;
    push(name, LAT, m_d, fd, m_cnt, m_fdt);
    push({name, "_post"}, LAT + 1, m_d, 1'b0, m_cnt, m_fdt);
    latch = l;
    pulse = p;
    tick(LAT + 2);
  endtask

  task automatic pulse_step(input string name, input logic d, input int cnt, input bit fd);
    act(name, latch, 1'b1, d, cnt, fd);
    pulse = 1'b0;
    tick(LAT + 1);
  endtask

  // Expectation for a change not driven through the synchronizers.
  task automatic settle(input string name, input logic d, input int cnt);
    m_d   = d;
    m_cnt = cnt;
    push(name, LAT, m_d, 1'b0, m_cnt, m_fdt);
    tick(LAT + 2);
  endtask

  initial begin
    logic [7:0] ff_tab;
    fd_total     = 0;
    tests_run    = 0;
    tests_failed = 0;
    m_d   = 1'b1;
    m_cnt = 0;
    m_fdt = 0;
    reset   = 1'b1;
    latch   = 1'b0;
    pulse   = 1'b0;
    buttons = '0;
    tick(3);
    reset = 1'b0;
    push("reset_state", 1, 1'b1, 1'b0, 0, 0);
    tick(2);

    for (int i = 0; i < 5; i++) pulse_step($sformatf("idle_pulse%0d", i), 1'b1, 0, 1'b0);

    // Full frame: A, Select, Right pressed; pin after pulses 1..8 is 1,0,1,1,1,1,0,0.
    buttons = 8'b1000_0101;
    act("ff_latch", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    act("ff_unlatch", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    buttons = 8'h7A;
    ff_tab  = 8'b0011_1101;
    for (int i = 1; i <= 8; i++)
      pulse_step($sformatf("ff_pulse%0d", i), ff_tab[i-1], i, i == 8);
    pulse_step("ff_pulse9", 1'b0, 8, 1'b0);

    // Live load while latch is held high.
    buttons = 8'h00;
    act("ll_latch", 1'b1, 1'b0, 1'b1, 0, 1'b0);
    buttons[0] = 1'b1;
    settle("ll_btn_press", 1'b0, 0);
    buttons[0] = 1'b0;
    settle("ll_btn_release", 1'b1, 0);
    act("ll_unlatch", 1'b0, 1'b0, 1'b1, 0, 1'b0);

    // Abort: three shifts, then re-latch with everything pressed.
    act("ab_latch", 1'b1, 1'b0, 1'b1, 0, 1'b0);
    act("ab_unlatch", 1'b0, 1'b0, 1'b1, 0, 1'b0);
    for (int i = 1; i <= 3; i++) pulse_step($sformatf("ab_pulse%0d", i), 1'b1, i, 1'b0);
    buttons = 8'hFF;
    act("ab_relatch", 1'b1, 1'b0, 1'b0, 0, 1'b0);
    act("ab_unlatch2", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 1; i <= 8; i++) pulse_step($sformatf("ab_shift%0d", i), 1'b0, i, i == 8);

    // Edge collisions on the same synchronized cycle.
    buttons = 8'b1000_0101;
    act("col_latch_rise", 1'b1, 1'b1, 1'b0, 0, 1'b0);
    pulse = 1'b0;
    tick(LAT + 1);
    act("col_latch_fall", 1'b0, 1'b1, 1'b1, 1, 1'b0);
    pulse = 1'b0;
    tick(LAT + 1);

    // Reset mid-frame after four shifts, latch already high at release.
    pulse_step("rst_pulse2", 1'b0, 2, 1'b0);
    pulse_step("rst_pulse3", 1'b1, 3, 1'b0);
    pulse_step("rst_pulse4", 1'b1, 4, 1'b0);
    latch = 1'b1;
    reset = 1'b1;
    m_d   = 1'b1;
    m_cnt = 0;
    push("rst_applied", 1, 1'b1, 1'b0, 0, m_fdt);
    tick(4);
    push("rst_held", 1, 1'b1, 1'b0, 0, m_fdt);
    tick(2);
    reset = 1'b0;
    push("rst_reload_pre", LAT - 1, 1'b1, 1'b0, 0, m_fdt);
    push("rst_reload", LAT, 1'b0, 1'b0, 0, m_fdt);
    m_d = 1'b0;
    tick(LAT + 2);
    act("rst_unlatch", 1'b0, 1'b0, 1'b0, 0, 1'b0);
    pulse_step("rst_pulse_after", 1'b1, 1, 1'b0);

    for (int i = 0; i < 50 && q.size() > 0; i++) tick(1);
    while (q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: never compared, due cycle %0d, run ended at %0d", q[0].name, q[0].due, cycle);
      void'(q.pop_front());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
